// File: rtl/lane_interleave_mux.sv
// lane_interleave_mux: N-lane to 1-lane frame interleaver; optional parity_out under LANE_MUX_PARITY_EN
module lane_interleave_mux #(
   parameter int DATA_W = 8,
   parameter int LANES = 4,
   localparam int LANE_W = $clog2(LANES)
) (
   input  logic                      bclk,
   input  logic                      reset,
   input  logic                      en,
   input  logic [LANES-1:0]          valid_in,
   input  logic [LANES*DATA_W-1:0]   data_in,
   output logic                      in_take,
   output logic                      valid_out,
   output logic [DATA_W-1:0]         data_out,
   output logic [LANE_W-1:0]         lane_out,
   output logic                      frame_start
`ifdef LANE_MUX_PARITY_EN
   ,
   output logic                      parity_out
`endif
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);
   state_t state_q, state_d;
   logic [LANE_W-1:0] sel_q, sel_d;
   logic [LANES-1:0] buf_v_q, buf_v_d;
   logic [DATA_W-1:0] buf_d_q [LANES];
   logic [DATA_W-1:0] buf_d_d [LANES];
   logic valid_out_q, valid_out_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [LANE_W-1:0] lane_out_q, lane_out_d;
   logic frame_start_q, frame_start_d;
   logic run_q, last_q;
   assign run_q = state_q == RUN;
   assign last_q = sel_q == LAST;
   assign in_take = en & (!run_q | last_q);
   always_comb begin
      state_d = state_q;
      sel_d = sel_q;
      buf_v_d = buf_v_q;
      buf_d_d = buf_d_q;
      valid_out_d = run_q ? buf_v_q[sel_q] : 1'b0;
      lane_out_d = run_q ? sel_q : '0;
      frame_start_d = run_q & (sel_q == '0);
      data_out_d = (run_q & buf_v_q[sel_q]) ? buf_d_q[sel_q] : data_out_q;
      if (run_q) begin
         sel_d = sel_q + LANE_W'(1);
         if (last_q & !en) begin
            state_d = IDLE;
            sel_d = '0;
            buf_v_d = '0;
            for (int k = 0; k < LANES; k++) buf_d_d[k] = '0;
         end
      end
      // Recapture overrides the slot advance; the output above already used the old buffer
      if (in_take) begin
         state_d = RUN;
         sel_d = '0;
         buf_v_d = valid_in;
         for (int k = 0; k < LANES; k++) buf_d_d[k] = data_in[k*DATA_W +: DATA_W];
      end
   end
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q <= '0;
         buf_v_q <= '0;
         buf_d_q <= '{default: '0};
         valid_out_q <= 1'b0;
         data_out_q <= '0;
         lane_out_q <= '0;
         frame_start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q <= sel_d;
         buf_v_q <= buf_v_d;
         buf_d_q <= buf_d_d;
         valid_out_q <= valid_out_d;
         data_out_q <= data_out_d;
         lane_out_q <= lane_out_d;
         frame_start_q <= frame_start_d;
      end
   end
   assign valid_out = valid_out_q;
   assign data_out = data_out_q;
   assign lane_out = lane_out_q;
   assign frame_start = frame_start_q;
`ifdef LANE_MUX_PARITY_EN
   logic parity_q, parity_d;
   assign parity_d = ^data_out_d;
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) parity_q <= 1'b0;
      else parity_q <= parity_d;
   end
   assign parity_out = parity_q;
`endif
endmodule

// File: tb/tb_lane_interleave_mux.sv
// tb_lane_interleave_mux: table-driven check of lane_interleave_mux (LANES=4, DATA_W=8)
module tb_lane_interleave_mux;
   logic bclk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b0;
   logic [3:0] valid_in = '0;
   logic [31:0] data_in = '0;
   logic in_take, valid_out, frame_start;
   logic [7:0] data_out;
   logic [1:0] lane_out;
`ifdef LANE_MUX_PARITY_EN
   logic parity_out;
`endif
   int checks = 0;
   int errors = 0;

   lane_interleave_mux #(.DATA_W(8), .LANES(4)) dut (
      .bclk(bclk), .reset(reset), .en(en), .valid_in(valid_in), .data_in(data_in),
      .in_take(in_take), .valid_out(valid_out), .data_out(data_out),
      .lane_out(lane_out), .frame_start(frame_start)
`ifdef LANE_MUX_PARITY_EN
      , .parity_out(parity_out)
`endif
   );

   always #5 bclk = ~bclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] l, input logic fs);
      chk({tag, " valid_out"}, 32'(valid_out), 32'(v));
      chk({tag, " data_out"}, 32'(data_out), 32'(d));
      chk({tag, " lane_out"}, 32'(lane_out), 32'(l));
      chk({tag, " frame_start"}, 32'(frame_start), 32'(fs));
   endtask

   typedef struct {
      logic en;
      logic [3:0] v;
      logic [31:0] d;
      logic take;
      logic vo;
      logic [7:0] dout;
      logic [1:0] lane;
      logic fs;
   } vec_t;
   vec_t tbl[22];

   initial begin
      // single frame, en pulsed once
      tbl[0]  = '{1'b1, 4'hF, 32'h44332211, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1};
      tbl[2]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b1, 8'h22, 2'd1, 1'b0};
      tbl[3]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b1, 8'h33, 2'd2, 1'b0};
      tbl[4]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b1, 8'h44, 2'd3, 1'b0};
      tbl[5]  = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 8'h44, 2'd0, 1'b0};
      // two back-to-back frames A then B
      tbl[6]  = '{1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 1'b0, 8'h44, 2'd0, 1'b0};
      tbl[7]  = '{1'b1, 4'hF, 32'hB3B2B1B0, 1'b0, 1'b1, 8'hA0, 2'd0, 1'b1};
      tbl[8]  = '{1'b1, 4'hF, 32'hB3B2B1B0, 1'b0, 1'b1, 8'hA1, 2'd1, 1'b0};
      tbl[9]  = '{1'b1, 4'hF, 32'hB3B2B1B0, 1'b0, 1'b1, 8'hA2, 2'd2, 1'b0};
      tbl[10] = '{1'b1, 4'hF, 32'hB3B2B1B0, 1'b1, 1'b1, 8'hA3, 2'd3, 1'b0};
      tbl[11] = '{1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 8'hB0, 2'd0, 1'b1};
      tbl[12] = '{1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 8'hB1, 2'd1, 1'b0};
      tbl[13] = '{1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 8'hB2, 2'd2, 1'b0};
      tbl[14] = '{1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, 8'hB3, 2'd3, 1'b0};
      tbl[15] = '{1'b0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, 8'hB3, 2'd0, 1'b0};
      // idle lane 2, inputs toggling after capture
      tbl[16] = '{1'b1, 4'hB, 32'h44332211, 1'b1, 1'b0, 8'hB3, 2'd0, 1'b0};
      tbl[17] = '{1'b0, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b1, 8'h11, 2'd0, 1'b1};
      tbl[18] = '{1'b0, 4'hF, 32'h12345678, 1'b0, 1'b1, 8'h22, 2'd1, 1'b0};
      tbl[19] = '{1'b0, 4'h0, 32'h9ABCDEF0, 1'b0, 1'b0, 8'h22, 2'd2, 1'b0};
      tbl[20] = '{1'b0, 4'h5, 32'h0F0F0F0F, 1'b0, 1'b1, 8'h44, 2'd3, 1'b0};
      tbl[21] = '{1'b0, 4'h0, 32'h00000000, 1'b0, 1'b0, 8'h44, 2'd0, 1'b0};

      #2;
      chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
      chk("reset in_take", 32'(in_take), 32'd0);
`ifdef LANE_MUX_PARITY_EN
      chk("reset parity_out", 32'(parity_out), 32'd0);
`endif
      @(negedge bclk);
      reset = 1'b0;
      for (int i = 0; i < 22; i++) begin
         @(negedge bclk);
         en = tbl[i].en;
         valid_in = tbl[i].v;
         data_in = tbl[i].d;
         #1;
         chk($sformatf("row%0d in_take", i), 32'(in_take), 32'(tbl[i].take));
         @(posedge bclk);
         #1;
         chk_out($sformatf("row%0d", i), tbl[i].vo, tbl[i].dout, tbl[i].lane, tbl[i].fs);
      end

      // async reset right after lane 1 is emitted
      @(negedge bclk);
      en = 1'b1; valid_in = 4'hF; data_in = 32'h88776655;
      @(negedge bclk);
      en = 1'b0;
      @(posedge bclk);
      @(posedge bclk);
      #1;
      chk("midframe lane1 lane_out", 32'(lane_out), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_out("async reset", 1'b0, 8'h00, 2'd0, 1'b0);
      @(negedge bclk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge bclk);
         #1;
         chk($sformatf("post reset idle%0d valid_out", i), 32'(valid_out), 32'd0);
      end
      @(negedge bclk);
      en = 1'b1;
      #1;
      chk("restart in_take", 32'(in_take), 32'd1);
      @(negedge bclk);
      en = 1'b0;
      #1;
      chk("restart slot0 in_take", 32'(in_take), 32'd0);
      @(posedge bclk);
      #1;
      chk_out("restart lane0", 1'b1, 8'h55, 2'd0, 1'b1);
`ifdef LANE_MUX_PARITY_EN
      repeat (4) @(posedge bclk);
      @(negedge bclk);
      en = 1'b1; valid_in = 4'h3; data_in = 32'h00000307;
      @(negedge bclk);
      en = 1'b0;
      @(posedge bclk);
      #1;
      chk("parity 07 data_out", 32'(data_out), 32'h07);
      chk("parity 07", 32'(parity_out), 32'd1);
      @(posedge bclk);
      #1;
      chk("parity 03 data_out", 32'(data_out), 32'h03);
      chk("parity 03", 32'(parity_out), 32'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/lane_interleave_mux.md
# lane_interleave_mux

Parametrised N-lane to 1-lane time-division interleaver for the PHY transmit path. Each frame it captures one word per lane coherently into a frame buffer, then serialises the buffered lanes onto a single output, one per clock, in fixed lane order. It is a single-clock successor to the two-phase 2:1 byte mux, with generic width and lane count, a run/idle state machine and frame markers.

## Interface
- DATA_W, 8, width of each lane word.
- LANES, 4, number of input lanes; legal range 2..16.
- LANE_W, $clog2(LANES), width of lane_out; derived, not overridden.

- bclk  in  1  single clock; all flops on rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; sampled at frame boundaries only.
- valid_in  in  LANES  per-lane valid; bit k belongs to lane k.
- data_in  in  LANES*DATA_W  lane k in bits [k*DATA_W +: DATA_W].
- in_take  out  1  combinational; high when the current edge captures a frame.
- valid_out  out  1  registered valid of the lane being emitted.
- data_out  out  DATA_W  registered output word.
- lane_out  out  LANE_W  index of the lane being emitted.
- frame_start  out  1  high while lane 0 of a frame is on the output.

## Operation
- States: IDLE and RUN. The slot counter sel runs 0..LANES-1. The frame buffer holds buf_v[LANES] and buf_d[LANES].
- in_take = en & (state==IDLE | (state==RUN & sel==LANES-1)).
- IDLE:
  - valid_out=0, frame_start=0, lane_out=0; data_out holds its value.
  - On an edge with en=1: capture valid_in/data_in into the buffer, sel<=0, go to RUN.
- RUN, every edge:
  - valid_out<=buf_v[sel], lane_out<=sel, frame_start<=(sel==0).
  - data_out<=buf_d[sel] only if buf_v[sel]=1; otherwise data_out holds its previous value.
  - If sel==LANES-1 and en=1: recapture the buffer and set sel<=0. This gives back-to-back frames with no bubble.
  - If sel==LANES-1 and en=0: go to IDLE and clear the buffer.
  - Otherwise: sel<=sel+1.
- en is ignored mid-frame. A frame always completes all LANES slots once started.
- The output of buf[sel] uses buffer contents from before the same-edge recapture.
- Reset (async, any time, including mid-frame):
  - state=IDLE, sel=0, buffer cleared.
  - valid_out=0, data_out=0, lane_out=0, frame_start=0.
  - The frame in flight is discarded.

## Timing
- The frame captured at edge E emits lane k after edge E+1+k, for k=0..LANES-1.
- Frame capture edges are E, E+LANES, E+2·LANES… while en stays high.
- Upstream holds data_in/valid_in stable whenever in_take=1, and may change them freely otherwise.
- With continuous en the output bandwidth is one lane word per cycle, 100% slot occupancy. Idle lanes appear as valid_out=0 slots.
- Release of reset: the first capture occurs on the first rising edge with en=1.

## Configuration
- LANE_MUX_PARITY_EN:
  - Defined: adds output port parity_out (1 bit, registered, reset 0), equal to the even parity (XOR reduction) of the data_out value presented in the same cycle. It updates whenever data_out updates and holds otherwise.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset mid-frame: assert reset after lane 1 is emitted -> all outputs 0 immediately; state IDLE; no further valid_out until en is re-asserted.
- Single frame, LANES=4, DATA_W=8:
  - Stimulus: en pulsed for one edge E, data_in={8'h44,8'h33,8'h22,8'h11}, valid_in=4'hF.
  - Required: after edges E+1..E+4, data_out=11,22,33,44; lane_out=0..3; frame_start only at E+1; then IDLE with valid_out=0.
- Continuous en, two frames: frames A0..A3 then B0..B3 -> 8 consecutive valid_out=1 cycles with no gap; in_take high at E and E+4 only.
- Idle lane: valid_in=4'b1011 with data 11,22,33,44 -> slot 2 shows valid_out=0 and data_out=22 (held); slot 3 shows 44.
- Input change outside in_take: data_in toggles during slots 1..3 -> the emitted words match the values captured at the in_take edge.
- LANE_MUX_PARITY_EN defined: data_out=8'h07 -> parity_out=1; data_out=8'h03 -> parity_out=0; after reset parity_out=0.
